// File: rtl/hmmm_pkg.sv
// Shared definitions for the hmmm data path: bus/address widths and RAM controller states.
package hmmm_pkg;

   localparam int unsigned DEF_ADDR_W = 8;
   localparam int unsigned DEF_DATA_W = 16;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_t;

endpackage : hmmm_pkg

// File: rtl/ram_array.sv
// Single-write-port storage array with synchronous write and combinational read.
module ram_array #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata_c
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // Synchronous write; contents are defined by the controller's zero-fill, not by reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata_c = mem[raddr];

endmodule : ram_array

// File: rtl/hmmm_ram.sv
// Word-addressed data memory behind the MDR: MAR, zero-fill after reset, CPU and loader write ports.
module hmmm_ram
   import hmmm_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mar_in,
   input  logic              mdr_in,
   input  logic [DATA_W-1:0] data,
   input  logic [DATA_W-1:0] ram_in,
   output logic [DATA_W-1:0] ram_out,
   output logic              ready,
   input  logic              load_valid,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_ready
);

   state_t            state;
   logic [ADDR_W-1:0] clr_cnt;
   logic [ADDR_W-1:0] mar;

   logic              wr_en_c;
   logic [ADDR_W-1:0] wr_addr_c;
   logic [DATA_W-1:0] wr_data_c;
   logic [DATA_W-1:0] rd_data_c;

   // Only the low ADDR_W bus bits address the array.
   logic data_unused_c;
   assign data_unused_c = ^data[DATA_W-1:ADDR_W];

   // CPU writes always win the port, so the loader is stalled while mdr_in is high.
   assign load_ready = (state == IDLE) && !mdr_in;

   // Write-port arbitration: zero-fill, then CPU, then loader.
   always_comb begin
      wr_en_c   = 1'b0;
      wr_addr_c = mar;
      wr_data_c = '0;
      if (!rst) begin
         if (state == CLEAR) begin
            wr_en_c   = 1'b1;
            wr_addr_c = clr_cnt;
         end else if (mdr_in) begin
            wr_en_c   = 1'b1;
            wr_addr_c = mar;
            wr_data_c = ram_in;
         end else if (load_valid) begin
            wr_en_c   = 1'b1;
            wr_addr_c = load_addr;
            wr_data_c = load_data;
         end
      end
   end

   ram_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_array (
      .clk     (clk),
      .we      (wr_en_c),
      .waddr   (wr_addr_c),
      .wdata   (wr_data_c),
      .raddr   (mar),
      .rdata_c (rd_data_c)
   );

   // Controller FSM, MAR and the write-first read register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CLEAR;
         clr_cnt <= '0;
         mar     <= '0;
         ram_out <= '0;
         ready   <= 1'b0;
      end else begin
         case (state)
            CLEAR: begin
               clr_cnt <= clr_cnt + ADDR_W'(1);
               ram_out <= '0;
               if (clr_cnt == '1) begin
                  state <= IDLE;
                  ready <= 1'b1;
               end
            end
            IDLE: begin
               if (mar_in) begin
                  mar <= data[ADDR_W-1:0];
               end
               if (wr_en_c && (wr_addr_c == mar)) begin
                  ram_out <= wr_data_c;
               end else begin
                  ram_out <= rd_data_c;
               end
            end
            default: begin
               state <= CLEAR;
               ready <= 1'b0;
            end
         endcase
      end
   end

endmodule : hmmm_ram

// File: tb/tb_hmmm_ram.sv
// Scoreboard bench for hmmm_ram: stimulus queues expected outputs, a negedge monitor checks them.
module tb_hmmm_ram;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 16;

   localparam int K_RAM_OUT    = 0;
   localparam int K_READY      = 1;
   localparam int K_LOAD_READY = 2;

   typedef struct {
      int          cyc;
      int          kind;
      logic [15:0] val;
      string       name;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              mar_in;
   logic              mdr_in;
   logic [DATA_W-1:0] data;
   logic [DATA_W-1:0] ram_in;
   logic [DATA_W-1:0] ram_out;
   logic              ready;
   logic              load_valid;
   logic [ADDR_W-1:0] load_addr;
   logic [DATA_W-1:0] load_data;
   logic              load_ready;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   hmmm_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .mar_in     (mar_in),
      .mdr_in     (mdr_in),
      .data       (data),
      .ram_in     (ram_in),
      .ram_out    (ram_out),
      .ready      (ready),
      .load_valid (load_valid),
      .load_addr  (load_addr),
      .load_data  (load_data),
      .load_ready (load_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every expectation due in the current cycle.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         exp_t e;
         logic [15:0] act;
         e = sb.pop_front();
         case (e.kind)
            K_RAM_OUT: act = ram_out;
            K_READY:   act = {15'd0, ready};
            default:   act = {15'd0, load_ready};
         endcase
         checks++;
         if (e.cyc != cyc || act !== e.val) begin
            errors++;
            $display("FAIL %s cyc=%0d: got 0x%04h, expected 0x%04h (due cyc %0d)",
                     e.name, cyc, act, e.val, e.cyc);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input int kind, input logic [15:0] val, input string name);
      exp_t e;
      e.cyc  = cyc;
      e.kind = kind;
      e.val  = val;
      e.name = name;
      sb.push_back(e);
   endtask

   task automatic set_mar(input logic [15:0] bus);
      mar_in = 1'b1;
      data   = bus;
      tick();
      mar_in = 1'b0;
   endtask

   task automatic read_check(input logic [15:0] bus, input logic [15:0] val, input string name);
      set_mar(bus);
      tick();
      expect_out(K_RAM_OUT, val, name);
   endtask

   task automatic cpu_write(input logic [15:0] val, input string name);
      mdr_in = 1'b1;
      ram_in = val;
      tick();
      mdr_in = 1'b0;
      expect_out(K_RAM_OUT, val, name);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // Full clear after reset release: ready low for 256 edges, ram_out zero throughout.
   task automatic check_clear(input int already_done);
      expect_out(K_READY, 16'd0, "ready_after_reset");
      expect_out(K_RAM_OUT, 16'd0, "ram_out_after_reset");
      for (int i = already_done + 1; i < 256; i++) begin
         tick();
         expect_out(K_READY, 16'd0, "ready_in_clear");
         expect_out(K_RAM_OUT, 16'd0, "ram_out_in_clear");
      end
      tick();
      expect_out(K_READY, 16'd1, "ready_after_clear");
      expect_out(K_RAM_OUT, 16'd0, "ram_out_after_clear");
   endtask

   initial begin
      rst        = 1'b0;
      mar_in     = 1'b0;
      mdr_in     = 1'b0;
      data       = '0;
      ram_in     = '0;
      load_valid = 1'b0;
      load_addr  = '0;
      load_data  = '0;
      #1;

      // Reset and zero-fill; loader is refused during clear.
      do_reset();
      load_valid = 1'b1;
      load_addr  = 8'h77;
      load_data  = 16'h7777;
      expect_out(K_LOAD_READY, 16'd0, "load_ready_in_clear");
      check_clear(0);
      load_valid = 1'b0;
      read_check(16'h0077, 16'h0000, "clear_no_load_77");
      read_check(16'h00FF, 16'h0000, "clear_ff");
      read_check(16'h0000, 16'h0000, "clear_00");

      // Write then read with bypass.
      set_mar(16'h0012);
      cpu_write(16'hBEEF, "write_bypass_12");
      tick();
      expect_out(K_RAM_OUT, 16'hBEEF, "hold_12");

      // Upper bus bits are ignored when loading MAR.
      set_mar(16'hFF05);
      cpu_write(16'h0505, "write_05");
      read_check(16'hAB12, 16'hBEEF, "mask_read_12");
      read_check(16'h3405, 16'h0505, "mask_read_05");

      // Loader: two back-to-back words.
      load_valid = 1'b1;
      load_addr  = 8'h30;
      load_data  = 16'h1234;
      expect_out(K_LOAD_READY, 16'd1, "load_ready_30");
      tick();
      load_addr  = 8'h31;
      load_data  = 16'h5678;
      expect_out(K_LOAD_READY, 16'd1, "load_ready_31");
      tick();
      load_valid = 1'b0;
      read_check(16'h0031, 16'h5678, "load_read_31");
      read_check(16'h0030, 16'h1234, "load_read_30");

      // Conflict: CPU write to MAR=0x30 and load to 0x40 in the same cycle.
      mdr_in     = 1'b1;
      ram_in     = 16'hAAAA;
      load_valid = 1'b1;
      load_addr  = 8'h40;
      load_data  = 16'h4444;
      expect_out(K_LOAD_READY, 16'd0, "conflict_load_blocked");
      tick();
      expect_out(K_RAM_OUT, 16'hAAAA, "conflict_cpu_bypass");
      mdr_in = 1'b0;
      expect_out(K_LOAD_READY, 16'd1, "conflict_load_retry");
      tick();
      load_valid = 1'b0;
      expect_out(K_RAM_OUT, 16'hAAAA, "conflict_hold_30");
      read_check(16'h0040, 16'h4444, "conflict_read_40");
      read_check(16'h0030, 16'hAAAA, "conflict_read_30");

      // Loader write to the current MAR bypasses into ram_out (MAR=0x30).
      load_valid = 1'b1;
      load_addr  = 8'h30;
      load_data  = 16'h5555;
      tick();
      load_valid = 1'b0;
      expect_out(K_RAM_OUT, 16'h5555, "load_bypass_30");

      // Simultaneous mar_in and mdr_in: write lands at old MAR (0x30).
      mar_in = 1'b1;
      data   = 16'h0050;
      mdr_in = 1'b1;
      ram_in = 16'h6666;
      tick();
      mar_in = 1'b0;
      mdr_in = 1'b0;
      expect_out(K_RAM_OUT, 16'h6666, "both_bypass_old_mar");
      tick();
      expect_out(K_RAM_OUT, 16'h0000, "both_new_mar_50");
      read_check(16'h0030, 16'h6666, "both_read_30");

      // Reset mid-CLEAR restarts the full 256-cycle clear.
      do_reset();
      for (int i = 1; i <= 100; i++) tick();
      do_reset();
      check_clear(0);

      // Reset mid-IDLE wipes previously written data.
      set_mar(16'h0012);
      cpu_write(16'hBEEF, "rewrite_12");
      read_check(16'h0012, 16'hBEEF, "rewrite_read_12");
      do_reset();
      check_clear(0);
      read_check(16'h0012, 16'h0000, "wiped_12");

      repeat (3) tick();
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_hmmm_ram
